// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin selection, one outstanding AR burst,
// return beats steered to the owning requester with length/response/ID error checking.
module axi_rd_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [63:0] i_m0_addr,
  input  logic [7:0]  i_m0_len,
  input  logic        i_m1_req,
  input  logic [63:0] i_m1_addr,
  input  logic [7:0]  i_m1_len,
  output logic        o_m0_gnt,
  output logic        o_m1_gnt,
  output logic [63:0] o_m0_rdata,
  output logic        o_m0_rvalid,
  output logic        o_m0_rlast,
  output logic        o_m0_rerr,
  output logic [63:0] o_m1_rdata,
  output logic        o_m1_rvalid,
  output logic        o_m1_rlast,
  output logic        o_m1_rerr,
  output logic [3:0]  o_ar_id,
  output logic [63:0] o_ar_addr,
  output logic [7:0]  o_ar_len,
  output logic [2:0]  o_ar_size,
  output logic [1:0]  o_ar_burst,
  output logic        o_ar_valid,
  input  logic        i_ar_ready,
  input  logic [3:0]  i_r_id,
  input  logic [63:0] i_r_data,
  input  logic [1:0]  i_r_resp,
  input  logic        i_r_last,
  input  logic        i_r_valid,
  output logic        o_r_ready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr;
  logic        r_owner;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [7:0]  r_len;
  logic [63:0] r_addr;

  logic w_any;
  logic w_winner;
  logic w_hs;
  logic w_beat;
  logic w_beatErr;
  logic w_lastErr;

  // Pointer holds the last-served requester; under contention the other one wins.
  assign w_any     = i_m0_req | i_m1_req;
  assign w_winner  = (i_m0_req && i_m1_req) ? ~r_ptr : i_m1_req;
  assign w_hs      = (r_state == ADDR) && i_ar_ready;
  assign w_beat    = (r_state == DATA) && i_r_valid;
  assign w_beatErr = (i_r_resp != 2'b00) || (i_r_id != {3'b000, r_owner});
  assign w_lastErr = r_err || w_beatErr || (r_cnt != r_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ADDR;
      ADDR:    if (i_ar_ready) w_next = DATA;
      DATA:    if (i_r_valid && i_r_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
      r_len   <= 8'd0;
      r_addr  <= 64'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_any) begin
        r_owner <= w_winner;
        r_addr  <= w_winner ? i_m1_addr : i_m0_addr;
        r_len   <= w_winner ? i_m1_len  : i_m0_len;
      end
      if (w_hs) begin
        r_cnt <= 8'd0;
        r_err <= 1'b0;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 8'd1;
        if (i_r_last) begin
          r_err <= 1'b0;
          r_ptr <= r_owner;
        end else begin
          // A non-last beat at count 255 means the burst exceeds 256 beats; the wrapped
          // counter alone could miss that, so it is folded into the sticky flag.
          r_err <= r_err || w_beatErr || (r_cnt == 8'hFF);
        end
      end
    end
  end

  always_comb begin
    o_m0_gnt    = 1'b0;
    o_m1_gnt    = 1'b0;
    o_m0_rdata  = 64'd0;
    o_m0_rvalid = 1'b0;
    o_m0_rlast  = 1'b0;
    o_m0_rerr   = 1'b0;
    o_m1_rdata  = 64'd0;
    o_m1_rvalid = 1'b0;
    o_m1_rlast  = 1'b0;
    o_m1_rerr   = 1'b0;
    o_ar_id     = {3'b000, r_owner};
    o_ar_addr   = r_addr;
    o_ar_len    = r_len;
    o_ar_size   = 3'b011;
    o_ar_burst  = 2'b01;
    o_ar_valid  = (r_state == ADDR);
    o_r_ready   = (r_state == DATA);
    if (w_hs) begin
      if (r_owner) o_m1_gnt = 1'b1;
      else         o_m0_gnt = 1'b1;
    end
    if (w_beat) begin
      if (r_owner) begin
        o_m1_rdata  = i_r_data;
        o_m1_rvalid = 1'b1;
        o_m1_rlast  = i_r_last;
        o_m1_rerr   = i_r_last && w_lastErr;
      end else begin
        o_m0_rdata  = i_r_data;
        o_m0_rvalid = 1'b1;
        o_m0_rlast  = i_r_last;
        o_m0_rerr   = i_r_last && w_lastErr;
      end
    end
  end

endmodule
